// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared FSM state encodings and the default address width
// common to the sequencer and the PC register.
package pc_sequencer_pkg;
    localparam int DEF_DATA_SIZE = 2;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        ADVANCE = 3'd3,
        HALTED  = 3'd4
    } state_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: picks the next PC (same-cycle branch, pending branch, or increment)
// and flags when the increment wraps to zero.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int DataSize = DEF_DATA_SIZE
) (
    input  logic [DataSize-1:0] pc_value,
    input  logic                branch_en,
    input  logic [DataSize-1:0] branch_addr,
    input  logic                pend_valid,
    input  logic [DataSize-1:0] pend_addr,
    output logic [DataSize-1:0] next_pc,
    output logic                wrap
);
    always_comb begin
        next_pc = branch_en ? branch_addr : pend_valid ? pend_addr : pc_value + DataSize'(1);
        wrap = !branch_en && !pend_valid && (&pc_value);
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/consume handshake FSM that drives the PC register's next
// address and load strobe; every output is registered off the next state.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int DataSize = DEF_DATA_SIZE
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [DataSize-1:0] PC_VALUE,
    output logic [DataSize-1:0] PC_NEXT,
    output logic                PC_LOAD,
    output logic                MEM_REQ,
    input  logic                MEM_ACK,
    output logic                INSTR_VALID,
    input  logic                INSTR_READY,
    input  logic                BRANCH_EN,
    input  logic [DataSize-1:0] BRANCH_ADDR,
    input  logic                HALT,
    output logic                BUSY,
    output logic                WRAP
);
    state_t state, state_n;
    logic pend_valid, adv, mux_wrap;
    logic [DataSize-1:0] pend_addr, mux_next;

    pc_next_mux #(.DataSize(DataSize)) u_mux (
        .pc_value   (PC_VALUE),
        .branch_en  (BRANCH_EN),
        .branch_addr(BRANCH_ADDR),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .next_pc    (mux_next),
        .wrap       (mux_wrap)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = HALT ? HALTED : REQ;
            REQ:     state_n = MEM_ACK ? HOLD : REQ;
            HOLD:    state_n = INSTR_READY ? ADVANCE : HOLD;
            ADVANCE: state_n = HALT ? HALTED : REQ;
            HALTED:  state_n = HALT ? HALTED : REQ;
            default: state_n = IDLE;
        endcase
        adv = (state == HOLD) && INSTR_READY;
    end

    // Strobes are registered from state_n so each one lines up exactly with its state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            PC_NEXT     <= '0;
            PC_LOAD     <= 1'b0;
            MEM_REQ     <= 1'b0;
            INSTR_VALID <= 1'b0;
            BUSY        <= 1'b0;
            WRAP        <= 1'b0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
        end else begin
            state       <= state_n;
            MEM_REQ     <= state_n == REQ;
            INSTR_VALID <= state_n == HOLD;
            PC_LOAD     <= state_n == ADVANCE;
            BUSY        <= state_n inside {REQ, HOLD, ADVANCE};
            WRAP        <= adv && mux_wrap;
            if (adv)
                PC_NEXT <= mux_next;
            if (adv)
                pend_valid <= 1'b0;
            else if (BRANCH_EN && (state inside {REQ, ADVANCE, HALTED})) begin
                pend_valid <= 1'b1;
                pend_addr  <= BRANCH_ADDR;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: pairs the sequencer with a PC register model and checks
// each load against a queue of expected next addresses.
module tb_pc_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    logic mem_ack = 1'b0, instr_ready = 1'b0, branch_en = 1'b0, halt = 1'b0;
    logic [1:0] branch_addr = 2'd0, pc;
    logic [1:0] pc_next;
    logic pc_load, mem_req, instr_valid, busy, wrap;
    int errors = 0, checks = 0;
    logic [1:0] exp_q[$];

    pc_sequencer #(.DataSize(2)) dut (
        .CLK(clk), .RESET(rst), .PC_VALUE(pc), .PC_NEXT(pc_next), .PC_LOAD(pc_load),
        .MEM_REQ(mem_req), .MEM_ACK(mem_ack), .INSTR_VALID(instr_valid),
        .INSTR_READY(instr_ready), .BRANCH_EN(branch_en), .BRANCH_ADDR(branch_addr),
        .HALT(halt), .BUSY(busy), .WRAP(wrap)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= 2'd0;
        else if (pc_load) pc <= pc_next;

    task automatic wait_req(output bit to);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        to = (mem_req !== 1'b1);
    endtask

    task automatic fetch(input int ack_dly, output bit to);
        wait_req(to);
        repeat (ack_dly) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic consume(input bit br, input logic [1:0] ba, output bit to);
        instr_ready = 1'b1;
        branch_en = br;
        branch_addr = ba;
        @(negedge clk);
        instr_ready = 1'b0;
        branch_en = 1'b0;
        branch_addr = 2'd0;
        to = (pc_load !== 1'b1);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({pc_next, pc_load, mem_req, instr_valid, busy, wrap} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0000000", {pc_next, pc_load, mem_req, instr_valid, busy, wrap});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_req: mem_req=%b busy=%b required 1 1", mem_req, busy);
        end
    endtask

    task automatic test_sequential();
        bit t1, t2;
        logic [1:0] e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(2'((i + 1) % 4));
            fetch(0, t1);
            consume(1'b0, 2'd0, t2);
            e = exp_q.pop_front();
            checks++;
            if (t1 || t2 || pc_next !== e || wrap !== (i == 3)) begin
                errors++;
                $display("FAIL seq_%0d: timeout=%b pc_next=%0d wrap=%b required %0d %b", i, t1 | t2, pc_next, wrap, e, i == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (wrap !== 1'b0 || pc_load !== 1'b0 || pc !== 2'd0) begin
            errors++;
            $display("FAIL seq_after: wrap=%b pc_load=%b pc=%0d required 0 0 0", wrap, pc_load, pc);
        end
    endtask

    task automatic test_branch_same_cycle();
        bit t1, t2;
        logic [1:0] e;
        exp_q.push_back(2'd1);
        fetch(0, t1);
        consume(1'b0, 2'd0, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e) begin
            errors++;
            $display("FAIL br_setup: timeout=%b pc_next=%0d required %0d", t1 | t2, pc_next, e);
        end
        exp_q.push_back(2'd3);
        fetch(0, t1);
        checks++;
        if (pc !== 2'd1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL br_hold: pc=%0d instr_valid=%b required 1 1", pc, instr_valid);
        end
        consume(1'b1, 2'd3, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e || wrap !== 1'b0) begin
            errors++;
            $display("FAIL br_same: timeout=%b pc_next=%0d wrap=%b required %0d 0", t1 | t2, pc_next, wrap, e);
        end
        @(negedge clk);
        checks++;
        if (pc_load !== 1'b0 || pc !== 2'd3) begin
            errors++;
            $display("FAIL br_one_cycle: pc_load=%b pc=%0d required 0 3", pc_load, pc);
        end
    endtask

    task automatic test_pending();
        bit t1, t2;
        logic [1:0] e;
        wait_req(t1);
        branch_en = 1'b1;
        branch_addr = 2'd2;
        @(negedge clk);
        branch_en = 1'b0;
        branch_addr = 2'd0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_req !== 1'b1 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL pend_inflight_%0d: mem_req=%b instr_valid=%b required 1 0", i, mem_req, instr_valid);
            end
            @(negedge clk);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL pend_fetch_done: instr_valid=%b required 1", instr_valid);
        end
        exp_q.push_back(2'd2);
        consume(1'b0, 2'd0, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e || wrap !== 1'b0) begin
            errors++;
            $display("FAIL pend_target: timeout=%b pc_next=%0d wrap=%b required %0d 0", t1 | t2, pc_next, wrap, e);
        end
        exp_q.push_back(2'd3);
        fetch(0, t1);
        consume(1'b0, 2'd0, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e) begin
            errors++;
            $display("FAIL pend_cleared: timeout=%b pc_next=%0d required %0d", t1 | t2, pc_next, e);
        end
    endtask

    task automatic test_backpressure();
        bit t1, t2;
        logic [1:0] e;
        fetch(0, t1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || pc_load !== 1'b0 || pc !== 2'd3) begin
                errors++;
                $display("FAIL bp_hold_%0d: instr_valid=%b pc_load=%b pc=%0d required 1 0 3", i, instr_valid, pc_load, pc);
            end
            @(negedge clk);
        end
        exp_q.push_back(2'd0);
        consume(1'b0, 2'd0, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e || wrap !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: timeout=%b pc_next=%0d wrap=%b required %0d 1", t1 | t2, pc_next, wrap, e);
        end
    endtask

    task automatic test_halt();
        bit t1, t2;
        logic [1:0] e;
        exp_q.push_back(2'd1);
        fetch(0, t1);
        halt = 1'b1;
        consume(1'b0, 2'd0, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e) begin
            errors++;
            $display("FAIL halt_advance: timeout=%b pc_next=%0d required %0d", t1 | t2, pc_next, e);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || pc_load !== 1'b0 || pc !== 2'd1) begin
            errors++;
            $display("FAIL halt_halted: mem_req=%b busy=%b pc_load=%b pc=%0d required 0 0 0 1", mem_req, busy, pc_load, pc);
        end
        branch_en = 1'b1;
        branch_addr = 2'd3;
        @(negedge clk);
        branch_en = 1'b0;
        branch_addr = 2'd0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_stays: mem_req=%b required 0", mem_req);
        end
        halt = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL halt_resume: mem_req=%b required 1", mem_req);
        end
        exp_q.push_back(2'd3);
        fetch(0, t1);
        consume(1'b0, 2'd0, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e) begin
            errors++;
            $display("FAIL halt_pending: timeout=%b pc_next=%0d required %0d", t1 | t2, pc_next, e);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit t1, t2;
        logic [1:0] e;
        wait_req(t1);
        branch_en = 1'b1;
        branch_addr = 2'd2;
        mem_ack = 1'b1;
        @(negedge clk);
        branch_en = 1'b0;
        branch_addr = 2'd0;
        mem_ack = 1'b0;
        checks++;
        if (t1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold_setup: timeout=%b instr_valid=%b required 0 1", t1, instr_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pc_next, pc_load, mem_req, instr_valid, busy, wrap} !== 7'd0 || pc !== 2'd0) begin
            errors++;
            $display("FAIL rst_async: outputs=%b pc=%0d required 0000000 0", {pc_next, pc_load, mem_req, instr_valid, busy, wrap}, pc);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(2'd1);
        fetch(0, t1);
        consume(1'b0, 2'd0, t2);
        e = exp_q.pop_front();
        checks++;
        if (t1 || t2 || pc_next !== e) begin
            errors++;
            $display("FAIL rst_restart: timeout=%b pc_next=%0d required %0d", t1 | t2, pc_next, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch_same_cycle();
        test_pending();
        test_backpressure();
        test_halt();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
